// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: accept samples, sequence TAPS MAC cycles, drain, hand off result, arbitrate coefficient file.
// Optional FIR_SEQ_FLUSH_EN adds a flush input that zeroes the ring buffer through the write port.
module fir_mac_sequencer #(
  parameter int TAPS = 8,
  parameter int PIPE = 1,
  localparam int AW = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] coef_addr,
  output logic          acc_en,
  output logic          acc_clr,
  output logic          o_valid,
  input  logic          o_ready,
  input  logic          cfg_req,
  output logic          cfg_gnt,
`ifdef FIR_SEQ_FLUSH_EN
  input  logic          flush,
  output logic          wr_zero,
`endif
  output logic          busy
);
  // k must also count PIPE drain cycles, so never narrower than 3 bits
  localparam int KW = (AW + 1 > 3) ? AW + 1 : 3;
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);
  localparam logic [KW-1:0] K_DRN = KW'(PIPE - 1);
  typedef enum logic [2:0] {
    IDLE, MAC, DRAIN, OUT, CFG
`ifdef FIR_SEQ_FLUSH_EN
    , CLEAR
`endif
  } state_t;
  state_t r_state;
  logic [KW-1:0] r_k;
  logic [AW-1:0] r_wptr;
  logic w_idle, w_mac, w_take, w_clear;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_k <= '0;
      r_wptr <= '0;
    end else begin
      case (r_state)
        IDLE:
`ifdef FIR_SEQ_FLUSH_EN
          if (flush) begin
            r_state <= CLEAR;
            r_k <= '0;
          end else
`endif
          if (cfg_req) r_state <= CFG;
          else if (s_valid) begin
            r_state <= MAC;
            r_k <= '0;
          end
        MAC:
          if (r_k == K_LAST) begin
            r_wptr <= r_wptr + 1'b1;
            r_k <= '0;
            r_state <= (PIPE > 0) ? DRAIN : OUT;
          end else r_k <= r_k + 1'b1;
        DRAIN:
          if (r_k == K_DRN) begin
            r_k <= '0;
            r_state <= OUT;
          end else r_k <= r_k + 1'b1;
        OUT: if (o_ready) r_state <= IDLE;
        CFG: if (!cfg_req) r_state <= IDLE;
`ifdef FIR_SEQ_FLUSH_EN
        CLEAR:
          if (r_k == K_LAST) begin
            r_k <= '0;
            r_wptr <= '0;
            r_state <= IDLE;
          end else r_k <= r_k + 1'b1;
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
  assign w_idle = !rst && r_state == IDLE;
  assign w_mac = !rst && r_state == MAC;
`ifdef FIR_SEQ_FLUSH_EN
  assign w_clear = !rst && r_state == CLEAR;
  assign w_take = w_idle && !flush && !cfg_req;
  assign wr_zero = w_clear;
`else
  assign w_clear = 1'b0;
  assign w_take = w_idle && !cfg_req;
`endif
  always_comb begin
    s_ready = w_take;
    wr_en = (w_take && s_valid) || w_clear;
    wr_addr = rst ? '0 : w_clear ? r_k[AW-1:0] : r_wptr;
    rd_addr = rst ? '0 : r_wptr - r_k[AW-1:0];
    coef_addr = rst ? '0 : r_k[AW-1:0];
    acc_en = w_mac;
    acc_clr = w_mac && r_k == '0;
    o_valid = !rst && r_state == OUT;
    cfg_gnt = !rst && r_state == CFG && cfg_req;
    busy = !rst && r_state != IDLE;
  end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: table-driven cycle vectors plus hand-written latency, throughput and flush sequences.
module tb_fir_mac_sequencer;
  logic clk = 1'b0;
  logic rst, s_valid, o_ready, cfg_req;
  logic s_ready, wr_en, acc_en, acc_clr, o_valid, cfg_gnt, busy;
  logic [2:0] wr_addr, rd_addr, coef_addr;
`ifdef FIR_SEQ_FLUSH_EN
  logic flush = 1'b0;
  logic wr_zero;
`endif
  always #5 clk = ~clk;

  fir_mac_sequencer #(.TAPS(8), .PIPE(1)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr(rd_addr), .coef_addr(coef_addr),
    .acc_en(acc_en), .acc_clr(acc_clr), .o_valid(o_valid), .o_ready(o_ready),
    .cfg_req(cfg_req), .cfg_gnt(cfg_gnt),
`ifdef FIR_SEQ_FLUSH_EN
    .flush(flush), .wr_zero(wr_zero),
`endif
    .busy(busy)
  );

  typedef struct {
    logic r, sv, ordy, creq;
    logic [15:0] exp;
    string name;
  } vec_t;
  vec_t vq[$];
  int n_pass = 0, n_total = 0;

  function automatic logic [15:0] pk(input logic sr, we, input logic [2:0] wa, ra, ca,
                                     input logic ae, ac, ov, cg, bz);
    return {sr, we, wa, ra, ca, ae, ac, ov, cg, bz};
  endfunction

  function automatic logic [15:0] act();
    return {s_ready, wr_en, wr_addr, rd_addr, coef_addr, acc_en, acc_clr, o_valid, cfg_gnt, busy};
  endfunction

  task automatic chk(input string n, input logic [15:0] a, e);
    n_total++;
    if (a !== e) $display("FAIL %s: got %h expected %h", n, a, e);
    else n_pass++;
  endtask

  task automatic add(input logic r, sv, ordy, creq, input logic [15:0] e, input string n);
    vq.push_back('{r, sv, ordy, creq, e, n});
  endtask

  // accept at wptr=w, run n MAC cycles (newest sample first)
  task automatic add_mac(input logic [2:0] w, input int n);
    add(1'b0, 1'b1, 1'b1, 1'b0, pk(1'b1, 1'b1, w, w, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "accept");
    for (int i = 0; i < n; i++)
      add(1'b0, 1'b0, 1'b1, 1'b0,
          pk(1'b0, 1'b0, w, w - 3'(i), 3'(i), 1'b1, i == 0, 1'b0, 1'b0, 1'b1), "mac");
  endtask

  task automatic add_frame(input logic [2:0] w, input int hold);
    logic [2:0] b;
    b = w + 3'd1;
    add_mac(w, 8);
    add(1'b0, 1'b0, 1'b1, 1'b0, pk(1'b0, 1'b0, b, b, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "drain");
    for (int i = 0; i < hold; i++)
      add(1'b0, 1'b1, 1'b0, 1'b0, pk(1'b0, 1'b0, b, b, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), "hold");
    add(1'b0, 1'b0, 1'b1, 1'b0, pk(1'b0, 1'b0, b, b, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), "out");
  endtask

  task automatic wait_ov(output int n);
    n = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (o_valid) begin
        n = c;
        return;
      end
    end
  endtask

  initial begin
    int lat, thr;
    rst = 1'b1; s_valid = 1'b0; o_ready = 1'b0; cfg_req = 1'b0;
    add(1'b1, 1'b1, 1'b1, 1'b1, 16'h0, "reset");
    for (int w = 0; w < 8; w++) add_frame(3'(w), 0);
    add_frame(3'd0, 0);
    add_frame(3'd1, 5);
    add(1'b0, 1'b1, 1'b1, 1'b1, pk(1'b0, 1'b0, 3'd2, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "cfg_prio");
    add(1'b0, 1'b1, 1'b1, 1'b1, pk(1'b0, 1'b0, 3'd2, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), "cfg_gnt");
    add(1'b0, 1'b1, 1'b1, 1'b0, pk(1'b0, 1'b0, 3'd2, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "cfg_drop");
    add_frame(3'd2, 0);
    add_mac(3'd3, 4);
    add(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, "rst_mid");
    add(1'b0, 1'b0, 1'b1, 1'b0, pk(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "post_rst");
    add(1'b0, 1'b0, 1'b1, 1'b0, pk(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "no_ov");
    add_frame(3'd0, 0);
    foreach (vq[i]) begin
      rst = vq[i].r; s_valid = vq[i].sv; o_ready = vq[i].ordy; cfg_req = vq[i].creq;
      @(negedge clk);
      chk($sformatf("%s[%0d]", vq[i].name, i), act(), vq[i].exp);
      @(posedge clk); #1;
    end
    // latency and back-to-back throughput with o_ready tied high
    rst = 1'b0; s_valid = 1'b1; o_ready = 1'b1; cfg_req = 1'b0;
    @(negedge clk);
    chk("lat_accept", {s_ready, wr_en, wr_addr}, {1'b1, 1'b1, 3'd1});
    wait_ov(lat);
    chk("latency", 16'(lat), 16'd10);
    wait_ov(thr);
    chk("throughput", 16'(thr), 16'd11);
    s_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_after", {s_ready, busy, wr_addr}, {1'b1, 1'b0, 3'd3});
`ifdef FIR_SEQ_FLUSH_EN
    @(posedge clk); #1;
    flush = 1'b1; cfg_req = 1'b1; s_valid = 1'b1;
    @(negedge clk);
    chk("flush_prio", {s_ready, wr_en, cfg_gnt, wr_zero}, 4'b0);
    @(posedge clk); #1;
    flush = 1'b0; cfg_req = 1'b0; s_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("clear[%0d]", i), {wr_en, wr_zero, wr_addr, busy}, {1'b1, 1'b1, 3'(i), 1'b1});
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    @(negedge clk);
    chk("post_clear", {s_ready, wr_en, wr_zero, wr_addr}, {1'b1, 1'b1, 1'b0, 3'd0});
    @(posedge clk); #1;
    s_valid = 1'b0;
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
